// File: rtl/toy_arb_pkg.sv
// Shared definitions for the toy memory arbiter: FSM encodings, requester IDs,
// default widths and a one-hot helper.
package toy_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int          DEF_MEM_LAT = 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic RQ_CPU = 1'b0;
  localparam logic RQ_LD  = 1'b1;

  function automatic logic [1:0] rq_onehot(input logic id);
    return (id == RQ_LD) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/toy_rr_picker.sv
// Two-way round-robin select: a lone request wins outright, a tie goes to the
// requester that was not served last.
module toy_rr_picker
  import toy_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_pick
);

  always_comb begin
    o_pick = i_req;
    if (&i_req) o_pick = rq_onehot(~i_last);
  end

endmodule

// File: rtl/toy_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU and the loader.
// Optional build macro ARB_LOCK_EN adds CPU_LOCK/LD_LOCK for locked re-grants.
module toy_mem_arbiter
  import toy_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int          MEM_LAT = DEF_MEM_LAT
) (
  input  logic              CLK,
`ifdef ARB_LOCK_EN
  input  logic              CPU_LOCK,
  input  logic              LD_LOCK,
`endif
  input  logic              RESET,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_ACK,
  output logic [DATA_W-1:0] CPU_RDATA,
  input  logic              LD_REQ,
  input  logic              LD_WE,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_WDATA,
  output logic              LD_ACK,
  output logic [DATA_W-1:0] LD_RDATA,
  output logic              MEM_EN,
  output logic              WRITE_EN,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] D_IN,
  input  logic [DATA_W-1:0] D_OUT,
  output logic [1:0]        GNT,
  output logic              BUSY
);

  generate
    if (MEM_LAT < 1) begin : g_bad_lat
      $error("toy_mem_arbiter: MEM_LAT must be >= 1");
    end
  endgenerate

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [1:0]        r_state;
  logic              r_owner;
  logic              r_last;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ld_rdata;

  logic [1:0]        w_req;
  logic [1:0]        w_pick;
  logic              w_regrant;
  logic              w_sel;

  assign w_req = {LD_REQ, CPU_REQ};

  toy_rr_picker u_picker (
    .i_req  (w_req),
    .i_last (r_last),
    .o_pick (w_pick)
  );

`ifdef ARB_LOCK_EN
  logic r_lock_hold;
  logic w_owner_lock;

  // Lock is sampled in DONE and honoured only in the IDLE cycle right after it.
  assign w_owner_lock = (r_owner == RQ_LD) ? LD_LOCK : CPU_LOCK;
  assign w_regrant    = r_lock_hold && w_req[r_owner];

  always_ff @(posedge CLK) begin
    if (RESET) r_lock_hold <= 1'b0;
    else       r_lock_hold <= (r_state == ST_DONE) && w_owner_lock;
  end
`else
  assign w_regrant = 1'b0;
`endif

  assign w_sel = w_regrant ? r_owner : w_pick[RQ_LD];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_owner     <= RQ_CPU;
      r_last      <= RQ_LD;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_ld_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_pick) begin
            r_state <= ST_ACCESS;
            r_owner <= w_sel;
            r_we    <= (w_sel == RQ_LD) ? LD_WE    : CPU_WE;
            r_addr  <= (w_sel == RQ_LD) ? LD_ADDR  : CPU_ADDR;
            r_wdata <= (w_sel == RQ_LD) ? LD_WDATA : CPU_WDATA;
            r_cnt   <= CNT_W'(MEM_LAT - 1);
            if (!w_regrant) r_last <= w_sel;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
            if (!r_we) begin
              if (r_owner == RQ_LD) r_ld_rdata  <= D_OUT;
              else                  r_cpu_rdata <= D_OUT;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign MEM_EN    = (r_state == ST_ACCESS);
  assign WRITE_EN  = MEM_EN && r_we;
  assign ADDR      = r_addr;
  assign D_IN      = r_wdata;
  assign BUSY      = (r_state != ST_IDLE);
  assign GNT       = BUSY ? rq_onehot(r_owner) : 2'b00;
  assign CPU_ACK   = (r_state == ST_DONE) && (r_owner == RQ_CPU);
  assign LD_ACK    = (r_state == ST_DONE) && (r_owner == RQ_LD);
  assign CPU_RDATA = r_cpu_rdata;
  assign LD_RDATA  = r_ld_rdata;

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// Directed bench for toy_mem_arbiter: MEM_LAT=1 and MEM_LAT=3 instances share
// stimulus; inputs change and outputs are sampled on the falling edge.
module tb_toy_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RESET;
  logic       CPU_REQ, CPU_WE, LD_REQ, LD_WE;
  logic [7:0] CPU_ADDR, CPU_WDATA, LD_ADDR, LD_WDATA, D_OUT;
`ifdef ARB_LOCK_EN
  logic       CPU_LOCK, LD_LOCK;
`endif

  logic       cpu_ack, ld_ack, mem_en, write_en, busy;
  logic [7:0] cpu_rdata, ld_rdata, addr, d_in;
  logic [1:0] gnt;
  logic       cpu_ack_3, ld_ack_3, mem_en_3, write_en_3, busy_3;
  logic [7:0] cpu_rdata_3, ld_rdata_3, addr_3, d_in_3;
  logic [1:0] gnt_3;

  int passed = 0;
  int total  = 0;

  toy_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_dut1 (
    .CLK(clk),
`ifdef ARB_LOCK_EN
    .CPU_LOCK(CPU_LOCK), .LD_LOCK(LD_LOCK),
`endif
    .RESET(RESET),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_ACK(cpu_ack), .CPU_RDATA(cpu_rdata),
    .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA),
    .LD_ACK(ld_ack), .LD_RDATA(ld_rdata),
    .MEM_EN(mem_en), .WRITE_EN(write_en), .ADDR(addr), .D_IN(d_in), .D_OUT(D_OUT),
    .GNT(gnt), .BUSY(busy)
  );

  toy_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) u_dut3 (
    .CLK(clk),
`ifdef ARB_LOCK_EN
    .CPU_LOCK(CPU_LOCK), .LD_LOCK(LD_LOCK),
`endif
    .RESET(RESET),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_ACK(cpu_ack_3), .CPU_RDATA(cpu_rdata_3),
    .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA),
    .LD_ACK(ld_ack_3), .LD_RDATA(ld_rdata_3),
    .MEM_EN(mem_en_3), .WRITE_EN(write_en_3), .ADDR(addr_3), .D_IN(d_in_3), .D_OUT(D_OUT),
    .GNT(gnt_3), .BUSY(busy_3)
  );

  task automatic test_reset();
    RESET = 1'b1; CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
    LD_REQ = 1'b0; LD_WE = 1'b0; LD_ADDR = '0; LD_WDATA = '0; D_OUT = '0;
`ifdef ARB_LOCK_EN
    CPU_LOCK = 1'b0; LD_LOCK = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en got %b exp 0", mem_en); else passed++;
    total++; if (write_en !== 1'b0) $display("FAIL rst_write_en got %b exp 0", write_en); else passed++;
    total++; if (gnt !== 2'b00) $display("FAIL rst_gnt got %b exp 00", gnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passed++;
    total++; if (cpu_ack !== 1'b0 || ld_ack !== 1'b0) $display("FAIL rst_ack got %b%b exp 00", cpu_ack, ld_ack); else passed++;
    total++; if (cpu_rdata !== 8'h00 || ld_rdata !== 8'h00) $display("FAIL rst_rdata got %h/%h exp 00/00", cpu_rdata, ld_rdata); else passed++;
    total++; if (addr !== 8'h00 || d_in !== 8'h00) $display("FAIL rst_addr_din got %h/%h exp 00/00", addr, d_in); else passed++;
    RESET = 1'b0;
  endtask

  task automatic test_cpu_read();
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 8'h10; D_OUT = 8'hA5;
    @(negedge clk);
    total++; if (mem_en !== 1'b1) $display("FAIL rd_mem_en got %b exp 1", mem_en); else passed++;
    total++; if (write_en !== 1'b0) $display("FAIL rd_write_en got %b exp 0", write_en); else passed++;
    total++; if (addr !== 8'h10) $display("FAIL rd_addr got %h exp 10", addr); else passed++;
    total++; if (gnt !== 2'b01) $display("FAIL rd_gnt got %b exp 01", gnt); else passed++;
    total++; if (cpu_ack !== 1'b0) $display("FAIL rd_early_ack got %b exp 0", cpu_ack); else passed++;
    @(negedge clk);
    total++; if (cpu_ack !== 1'b1) $display("FAIL rd_ack got %b exp 1", cpu_ack); else passed++;
    total++; if (mem_en !== 1'b0) $display("FAIL rd_done_mem_en got %b exp 0", mem_en); else passed++;
    total++; if (gnt !== 2'b01) $display("FAIL rd_done_gnt got %b exp 01", gnt); else passed++;
    total++; if (cpu_rdata !== 8'hA5) $display("FAIL rd_rdata got %h exp a5", cpu_rdata); else passed++;
    total++; if (ld_ack !== 1'b0) $display("FAIL rd_ld_ack got %b exp 0", ld_ack); else passed++;
    CPU_REQ = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || gnt !== 2'b00) $display("FAIL rd_idle got busy=%b gnt=%b exp 0/00", busy, gnt); else passed++;
    total++; if (cpu_ack !== 1'b0) $display("FAIL rd_ack_width got %b exp 0", cpu_ack); else passed++;
    total++; if (cpu_rdata !== 8'hA5) $display("FAIL rd_rdata_hold got %h exp a5", cpu_rdata); else passed++;
  endtask

  task automatic test_ld_write();
    LD_REQ = 1'b1; LD_WE = 1'b1; LD_ADDR = 8'h20; LD_WDATA = 8'h3C; D_OUT = 8'h77;
    @(negedge clk);
    total++; if (mem_en !== 1'b1 || write_en !== 1'b1) $display("FAIL wr_strobes got %b%b exp 11", mem_en, write_en); else passed++;
    total++; if (addr !== 8'h20) $display("FAIL wr_addr got %h exp 20", addr); else passed++;
    total++; if (d_in !== 8'h3C) $display("FAIL wr_din got %h exp 3c", d_in); else passed++;
    total++; if (gnt !== 2'b10) $display("FAIL wr_gnt got %b exp 10", gnt); else passed++;
    @(negedge clk);
    total++; if (ld_ack !== 1'b1) $display("FAIL wr_ack got %b exp 1", ld_ack); else passed++;
    total++; if (mem_en !== 1'b0 || write_en !== 1'b0) $display("FAIL wr_done_strobes got %b%b exp 00", mem_en, write_en); else passed++;
    total++; if (ld_rdata !== 8'h00) $display("FAIL wr_ld_rdata got %h exp 00", ld_rdata); else passed++;
    total++; if (cpu_rdata !== 8'hA5) $display("FAIL wr_cpu_rdata got %h exp a5", cpu_rdata); else passed++;
    LD_REQ = 1'b0; LD_WE = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL wr_idle got busy=%b exp 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_gnt [12] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                                 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    logic       exp_cack [12] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic       exp_lack [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    RESET = 1'b1; CPU_REQ = 1'b1; LD_REQ = 1'b1; CPU_WE = 1'b0; LD_WE = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL b2b_reset_hold got busy=%b exp 0", busy); else passed++;
    RESET = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++; if (gnt !== exp_gnt[c]) $display("FAIL b2b_gnt c%0d got %b exp %b", c + 1, gnt, exp_gnt[c]); else passed++;
      total++; if (cpu_ack !== exp_cack[c] || ld_ack !== exp_lack[c])
        $display("FAIL b2b_ack c%0d got %b%b exp %b%b", c + 1, cpu_ack, ld_ack, exp_cack[c], exp_lack[c]);
      else passed++;
    end
    CPU_REQ = 1'b0; LD_REQ = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL b2b_idle got busy=%b exp 0", busy); else passed++;
  endtask

  task automatic test_long_latency();
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0; CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 8'h44; D_OUT = 8'h11;
    @(negedge clk);
    total++; if (mem_en_3 !== 1'b1 || gnt_3 !== 2'b01) $display("FAIL lat_c1 got en=%b gnt=%b exp 1/01", mem_en_3, gnt_3); else passed++;
    total++; if (addr_3 !== 8'h44) $display("FAIL lat_addr_c1 got %h exp 44", addr_3); else passed++;
    CPU_REQ = 1'b0; CPU_ADDR = 8'hFF; D_OUT = 8'h22;
    @(negedge clk);
    total++; if (mem_en_3 !== 1'b1 || cpu_ack_3 !== 1'b0) $display("FAIL lat_c2 got en=%b ack=%b exp 1/0", mem_en_3, cpu_ack_3); else passed++;
    total++; if (addr_3 !== 8'h44) $display("FAIL lat_addr_latched got %h exp 44", addr_3); else passed++;
    D_OUT = 8'h33;
    @(negedge clk);
    total++; if (mem_en_3 !== 1'b1 || cpu_ack_3 !== 1'b0) $display("FAIL lat_c3 got en=%b ack=%b exp 1/0", mem_en_3, cpu_ack_3); else passed++;
    total++; if (cpu_rdata_3 !== 8'h00) $display("FAIL lat_early_capture got %h exp 00", cpu_rdata_3); else passed++;
    @(negedge clk);
    total++; if (mem_en_3 !== 1'b0 || cpu_ack_3 !== 1'b1) $display("FAIL lat_c4 got en=%b ack=%b exp 0/1", mem_en_3, cpu_ack_3); else passed++;
    total++; if (cpu_rdata_3 !== 8'h33) $display("FAIL lat_rdata got %h exp 33", cpu_rdata_3); else passed++;
    D_OUT = 8'h44;
    @(negedge clk);
    total++; if (busy_3 !== 1'b0 || cpu_ack_3 !== 1'b0) $display("FAIL lat_c5 got busy=%b ack=%b exp 0/0", busy_3, cpu_ack_3); else passed++;
    total++; if (cpu_rdata_3 !== 8'h33) $display("FAIL lat_rdata_hold got %h exp 33", cpu_rdata_3); else passed++;
  endtask

  task automatic test_reset_abort();
    LD_REQ = 1'b1; LD_WE = 1'b0; LD_ADDR = 8'h30;
    @(negedge clk);
    total++; if (mem_en !== 1'b1 || gnt !== 2'b10) $display("FAIL abort_pre got en=%b gnt=%b exp 1/10", mem_en, gnt); else passed++;
    RESET = 1'b1;
    @(negedge clk);
    total++; if (mem_en !== 1'b0 || gnt !== 2'b00 || busy !== 1'b0) $display("FAIL abort_idle got en=%b gnt=%b busy=%b exp 0/00/0", mem_en, gnt, busy); else passed++;
    total++; if (ld_ack !== 1'b0) $display("FAIL abort_no_ack got %b exp 0", ld_ack); else passed++;
    RESET = 1'b0; CPU_REQ = 1'b1; CPU_WE = 1'b0;
    @(negedge clk);
    total++; if (gnt !== 2'b01 || mem_en !== 1'b1) $display("FAIL abort_regrant got gnt=%b en=%b exp 01/1", gnt, mem_en); else passed++;
    total++; if (ld_ack !== 1'b0) $display("FAIL abort_late_ack got %b exp 0", ld_ack); else passed++;
    CPU_REQ = 1'b0; LD_REQ = 1'b0;
    @(negedge clk);
    total++; if (cpu_ack !== 1'b1 || ld_ack !== 1'b0) $display("FAIL abort_cpu_ack got %b%b exp 10", cpu_ack, ld_ack); else passed++;
    @(negedge clk);
  endtask

  task automatic test_lock();
`ifdef ARB_LOCK_EN
    logic [1:0] exp_g [3] = '{2'b01, 2'b01, 2'b10};
`else
    logic [1:0] exp_g [3] = '{2'b01, 2'b10, 2'b01};
`endif
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0; CPU_REQ = 1'b1; LD_REQ = 1'b1; CPU_WE = 1'b0; LD_WE = 1'b0;
`ifdef ARB_LOCK_EN
    CPU_LOCK = 1'b1;
`endif
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
`ifdef ARB_LOCK_EN
      if (c == 3) CPU_LOCK = 1'b0;
`endif
      if (c % 3 == 1) begin
        total++; if (gnt !== exp_g[c / 3]) $display("FAIL lock_gnt c%0d got %b exp %b", c, gnt, exp_g[c / 3]); else passed++;
      end
    end
    CPU_REQ = 1'b0; LD_REQ = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL lock_idle got busy=%b exp 0", busy); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired after 100000 time units");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_ld_write();
    test_back_to_back();
    test_long_latency();
    test_reset_abort();
    test_lock();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
